// File: rtl/lc3b_mem_stage_pkg.sv
// Shared LC-3b types for the MEM stage: opcodes, control word, memory FSM states and write masks.
package lc3b_mem_stage_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0, OP_ADD  = 4'h1, OP_LDB  = 4'h2, OP_STB  = 4'h3,
        OP_JSR  = 4'h4, OP_AND  = 4'h5, OP_LDR  = 4'h6, OP_STR  = 4'h7,
        OP_RTI  = 4'h8, OP_NOT  = 4'h9, OP_LDI  = 4'hA, OP_STI  = 4'hB,
        OP_JMP  = 4'hC, OP_SHF  = 4'hD, OP_LEA  = 4'hE, OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic        mem_read;
        logic        mem_write;
        logic        load_regfile;
        logic [1:0]  wb_sel;
    } lc3b_control_word;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } lc3b_mem_state;

    localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
    localparam lc3b_mem_wmask WMASK_HI   = 2'b10;
    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

    // Word accesses always target the even byte of the pair.
    function automatic lc3b_word word_addr(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/lc3b_byte_align.sv
// Byte-lane steering for LDB (extract + sign-extend) and STB (lane replication + write mask).
module lc3b_byte_align
    import lc3b_mem_stage_pkg::*;
(
    input  logic        addr_lsb,
    input  logic [15:0] rdata,
    input  logic [7:0]  sdata_lo,
    output logic [15:0] ldb_data,
    output logic [1:0]  stb_wmask,
    output logic [15:0] stb_wdata
);

    logic [7:0] byte_s;

    // Odd addresses select the high byte lane.
    always_comb begin
        if (addr_lsb) begin
            byte_s    = rdata[15:8];
            stb_wmask = WMASK_HI;
        end else begin
            byte_s    = rdata[7:0];
            stb_wmask = WMASK_LO;
        end
        ldb_data  = {{8{byte_s[7]}}, byte_s};
        stb_wdata = {sdata_lo, sdata_lo};
    end

endmodule

// File: rtl/lc3b_mem_stage.sv
// LC-3b MEM stage: data-memory handshake, LDI/STI indirection, byte steering, MEM/WB register.
// Optional LC3B_MEM_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module lc3b_mem_stage
    import lc3b_mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  lc3b_control_word in_ctrl,
    input  logic [15:0]      in_addr,
    input  logic [15:0]      in_sdata,
    input  logic [2:0]       in_dr,
    input  logic [15:0]      in_pc,
    output logic             stall,
    output logic [15:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_resp,
    output logic             wb_valid,
    output lc3b_control_word wb_ctrl,
    output logic [15:0]      wb_result,
    output logic [2:0]       wb_dr,
    output logic [15:0]      wb_pc
`ifdef LC3B_MEM_STALL_COUNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    lc3b_mem_state state_r;
    logic [15:0]   ptr_r;

    logic        is_mem_s;
    logic        is_ind_s;
    logic        is_byte_s;
    logic        first_write_s;
    logic        second_write_s;
    logic [15:0] result_s;
    logic [15:0] ldb_data_s;
    logic [1:0]  stb_wmask_s;
    logic [15:0] stb_wdata_s;

    // Reset gates the request so an abandoned access drops the bus at once.
    assign is_mem_s       = in_valid & ~reset & (in_ctrl.mem_read | in_ctrl.mem_write);
    assign is_ind_s       = is_mem_s & ((in_ctrl.opcode == OP_LDI) | (in_ctrl.opcode == OP_STI));
    assign is_byte_s      = (in_ctrl.opcode == OP_LDB) | (in_ctrl.opcode == OP_STB);
    assign first_write_s  = in_ctrl.mem_write & ~in_ctrl.mem_read;
    assign second_write_s = (in_ctrl.opcode == OP_STI) & first_write_s;

    lc3b_byte_align u_byte_align (
        .addr_lsb  (in_addr[0]),
        .rdata     (mem_rdata),
        .sdata_lo  (in_sdata[7:0]),
        .ldb_data  (ldb_data_s),
        .stb_wmask (stb_wmask_s),
        .stb_wdata (stb_wdata_s)
    );

    // Request decode, stall and writeback value from state and held inputs.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = word_addr(in_addr);
        mem_byte_enable = WMASK_WORD;
        mem_wdata       = in_sdata;
        stall           = 1'b0;
        result_s        = in_addr;
        if ((state_r == ST_SECOND) && is_ind_s) begin
            mem_address = word_addr(ptr_r);
            stall       = ~mem_resp;
            if (second_write_s) begin
                mem_write = 1'b1;
            end else begin
                mem_read = 1'b1;
                result_s = mem_rdata;
            end
        end else if ((state_r == ST_FIRST) && is_mem_s) begin
            if (is_ind_s) begin
                mem_read = 1'b1;
                stall    = 1'b1;
            end else if (first_write_s) begin
                mem_write = 1'b1;
                stall     = ~mem_resp;
                if (is_byte_s) begin
                    mem_byte_enable = stb_wmask_s;
                    mem_wdata       = stb_wdata_s;
                end else begin
                    mem_byte_enable = WMASK_WORD;
                    mem_wdata       = in_sdata;
                end
            end else begin
                // Also covers a malformed word with both mem_read and mem_write set.
                mem_read = 1'b1;
                stall    = ~mem_resp;
                result_s = (in_ctrl.opcode == OP_LDB) ? ldb_data_s : mem_rdata;
            end
        end else begin
            stall = 1'b0;
        end
    end

    // Access FSM and indirect pointer capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FIRST;
            ptr_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_FIRST: begin
                    if (is_ind_s && mem_resp) begin
                        ptr_r   <= mem_rdata;
                        state_r <= ST_SECOND;
                    end else begin
                        state_r <= ST_FIRST;
                    end
                end
                ST_SECOND: begin
                    if (!is_ind_s || mem_resp) begin
                        state_r <= ST_FIRST;
                    end else begin
                        state_r <= ST_SECOND;
                    end
                end
                default: state_r <= ST_FIRST;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_result <= 16'h0000;
            wb_dr     <= 3'b000;
            wb_pc     <= 16'h0000;
        end else if (stall) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid  <= in_valid;
            wb_ctrl   <= in_ctrl;
            wb_result <= result_s;
            wb_dr     <= in_dr;
            wb_pc     <= in_pc;
        end
    end

`ifdef LC3B_MEM_STALL_COUNT_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'h0000_0000;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'h0000_0001;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_mem_stage.sv
// Self-checking bench for lc3b_mem_stage: directed scenarios then random instructions vs a memory model.
module tb_lc3b_mem_stage;
    import lc3b_mem_stage_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    lc3b_control_word in_ctrl;
    logic [15:0]      in_addr, in_sdata, in_pc;
    logic [2:0]       in_dr;
    logic             stall, mem_read, mem_write, mem_resp;
    logic [15:0]      mem_address, mem_wdata, mem_rdata;
    logic [1:0]       mem_byte_enable;
    logic             wb_valid;
    lc3b_control_word wb_ctrl;
    logic [15:0]      wb_result, wb_pc;
    logic [2:0]       wb_dr;
`ifdef LC3B_MEM_STALL_COUNT_EN
    logic [31:0]      stall_cycles;
`endif

    lc3b_mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_addr(in_addr), .in_sdata(in_sdata), .in_dr(in_dr), .in_pc(in_pc),
        .stall(stall), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_result(wb_result),
        .wb_dr(wb_dr), .wb_pc(wb_pc)
`ifdef LC3B_MEM_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];
    int errors = 0;
    int checks = 0;
    int exp_stall_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, act as memory, and compare against the spec-level model.
    task automatic run_instr(input logic valid, input lc3b_opcode op, input logic mr, input logic mw,
                             input logic [15:0] addr, input logic [15:0] sdata, input int lat_fix,
                             output int n_stall);
        lc3b_control_word c;
        logic [15:0] a_addr [0:1];
        logic        a_we   [0:1];
        logic [1:0]  a_be   [0:1];
        logic [15:0] a_wd   [0:1];
        logic [15:0] exp_res, p, w;
        logic [7:0]  b;
        logic [2:0]  dr;
        logic [15:0] pc;
        int nacc, k, wt, lat, cyc, sv;
        logic exp_st, done;

        c = '{opcode: op, mem_read: mr, mem_write: mw, load_regfile: 1'($urandom), wb_sel: 2'($urandom)};
        dr = 3'($urandom); pc = 16'($urandom);
        nacc = 0; exp_res = addr; n_stall = 0;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = 16'h0000; a_we[i] = 1'b0; a_be[i] = 2'b11; a_wd[i] = 16'h0000;
        end
        if (valid && (mr || mw)) begin
            if (op == OP_LDI || op == OP_STI) begin
                p = mem[addr[15:1]];
                a_addr[0] = addr & 16'hFFFE;
                a_addr[1] = p & 16'hFFFE;
                nacc = 2;
                if (op == OP_STI) begin
                    a_we[1] = 1'b1; a_wd[1] = sdata;
                end else begin
                    exp_res = mem[p[15:1]];
                end
            end else if (mr) begin
                a_addr[0] = addr & 16'hFFFE;
                nacc = 1;
                w = mem[addr[15:1]];
                if (op == OP_LDB) begin
                    b = addr[0] ? w[15:8] : w[7:0];
                    sv = int'(b);
                    if (sv >= 128) sv = sv - 256;
                    exp_res = 16'(sv);
                end else begin
                    exp_res = w;
                end
            end else begin
                a_addr[0] = addr & 16'hFFFE;
                a_we[0] = 1'b1;
                nacc = 1;
                if (op == OP_STB) begin
                    a_be[0] = addr[0] ? 2'b10 : 2'b01;
                    a_wd[0] = {sdata[7:0], sdata[7:0]};
                end else begin
                    a_wd[0] = sdata;
                end
            end
        end

        in_valid = valid; in_ctrl = c; in_addr = addr; in_sdata = sdata; in_dr = dr; in_pc = pc;
        k = 0; wt = 0; cyc = 0; done = 1'b0;
        lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (k < nacc) begin
                chk("mem_address", 32'(mem_address), 32'(a_addr[k]));
                chk("mem_read", 32'(mem_read), 32'(!a_we[k]));
                chk("mem_write", 32'(mem_write), 32'(a_we[k]));
                if (a_we[k]) begin
                    chk("byte_enable", 32'(mem_byte_enable), 32'(a_be[k]));
                    chk("wdata", 32'(mem_wdata), 32'(a_wd[k]));
                end
                mem_resp  = (wt == lat);
                mem_rdata = mem_resp ? mem[a_addr[k][15:1]] : 16'($urandom);
            end else begin
                chk("idle_read", 32'(mem_read), 32'h0);
                chk("idle_write", 32'(mem_write), 32'h0);
                mem_resp  = ($urandom_range(0, 1) == 0);
                mem_rdata = 16'($urandom);
            end
            #1;
            exp_st = (k < nacc) && !(mem_resp && (k == nacc - 1));
            chk("stall", 32'(stall), 32'(exp_st));
            if (exp_st) begin
                n_stall++;
                exp_stall_total++;
            end
            @(posedge clk); #1;
            if (k < nacc && mem_resp) begin
                if (a_we[k]) begin
                    if (a_be[k][0]) mem[a_addr[k][15:1]][7:0]  = a_wd[k][7:0];
                    if (a_be[k][1]) mem[a_addr[k][15:1]][15:8] = a_wd[k][15:8];
                end
                k++; wt = 0;
                lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
            end else if (k < nacc) begin
                wt++;
            end
            if (!exp_st) begin
                done = 1'b1;
                chk("wb_valid", 32'(wb_valid), 32'(valid));
                chk("wb_result", 32'(wb_result), 32'(exp_res));
                chk("wb_ctrl", 32'(wb_ctrl), 32'(c));
                chk("wb_dr", 32'(wb_dr), 32'(dr));
                chk("wb_pc", 32'(wb_pc), 32'(pc));
            end else begin
                chk("wb_bubble", 32'(wb_valid), 32'h0);
            end
            cyc++;
        end
        mem_resp = 1'b0;
        if (!done) begin
            checks++; errors++;
            $error("FAIL timeout observed=stall_stuck expected=completion op=%0d", op);
        end
    endtask

    initial begin
        int ns;
        lc3b_opcode op;
        logic v, mr, mw;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_addr = 16'h0000; in_sdata = 16'h0000;
        in_dr = 3'b000; in_pc = 16'h0000; mem_resp = 1'b0; mem_rdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_wb_result", 32'(wb_result), 32'h0);
        chk("rst_wb_pc", 32'(wb_pc), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        reset = 1'b0;
        exp_stall_total = 0;

        run_instr(1'b1, OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h0000, 0, ns);
        mem[16'h3000 >> 1] = 16'hBEEF;
        run_instr(1'b1, OP_LDR, 1'b1, 1'b0, 16'h3001, 16'h0000, 3, ns);
        chk("ldr_stall_cycles", 32'(ns), 32'd3);
        mem[16'h4000 >> 1] = 16'h80FF;
        run_instr(1'b1, OP_LDB, 1'b1, 1'b0, 16'h4001, 16'h0000, 1, ns);
        run_instr(1'b1, OP_STB, 1'b0, 1'b1, 16'h4000, 16'h12AB, 2, ns);
        chk("stb_mem_lane", 32'(mem[16'h4000 >> 1]), 32'h80AB);
        mem[16'h5000 >> 1] = 16'h6000;
        run_instr(1'b1, OP_STI, 1'b0, 1'b1, 16'h5000, 16'hCAFE, 1, ns);
        chk("sti_target", 32'(mem[16'h6000 >> 1]), 32'hCAFE);
        run_instr(1'b0, OP_LEA, 1'b0, 1'b0, 16'h0042, 16'h0000, 0, ns);
        run_instr(1'b1, OP_SHF, 1'b1, 1'b1, 16'h2223, 16'h5555, 0, ns);

        // Reset during the second access of an LDI.
        mem[16'h0100 >> 1] = 16'h0A10;
        in_valid = 1'b1; in_ctrl = '{opcode: OP_LDI, mem_read: 1'b1, mem_write: 1'b0, load_regfile: 1'b1, wb_sel: 2'b00};
        in_addr = 16'h0100;
        @(negedge clk);
        chk("ldi_first_addr", 32'(mem_address), 32'h0100);
        mem_resp = 1'b1; mem_rdata = mem[16'h0100 >> 1];
        #1;
        chk("ldi_first_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        chk("ldi_second_addr", 32'(mem_address), 32'h0A10);
        chk("ldi_second_read", 32'(mem_read), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_drops_read", 32'(mem_read), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_wb_valid2", 32'(wb_valid), 32'h0);
        exp_stall_total = 0;
        in_valid = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h7777;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("late_resp_read", 32'(mem_read), 32'h0);
        chk("late_resp_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("late_resp_wb", 32'(wb_valid), 32'h0);
        mem_resp = 1'b0;
        mem[16'h0A10 >> 1] = 16'h1357;
        run_instr(1'b1, OP_LDR, 1'b1, 1'b0, 16'h0A10, 16'h0000, 1, ns);

        // Stray responses with nothing live.
        for (int i = 0; i < 4; i++) run_instr(1'b0, OP_LDR, 1'b1, 1'b0, 16'($urandom), 16'h0000, 0, ns);

        for (int n = 0; n < 80; n++) begin
            v = 1'b1; mr = 1'b0; mw = 1'b0;
            case ($urandom_range(0, 8))
                0: op = OP_ADD;
                1: begin op = OP_LDR; mr = 1'b1; end
                2: begin op = OP_LDB; mr = 1'b1; end
                3: begin op = OP_STR; mw = 1'b1; end
                4: begin op = OP_STB; mw = 1'b1; end
                5: begin op = OP_LDI; mr = 1'b1; end
                6: begin op = OP_STI; mw = 1'b1; end
                7: begin op = OP_SHF; mr = 1'b1; mw = 1'b1; end
                default: begin op = OP_LDR; mr = 1'b1; v = 1'b0; end
            endcase
            run_instr(v, op, mr, mw, 16'($urandom), 16'($urandom), -1, ns);
        end

`ifdef LC3B_MEM_STALL_COUNT_EN
        chk("stall_cycles", stall_cycles, 32'(exp_stall_total));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
